down_counter_sync_timer: RTL and testbench
==========================================

Name: down_counter_sync_timer

Overview:
Synchronous loadable down-counter and timer. It is the count-down counterpart of the team's synchronous up-counter. The block loads a start value, decrements once per enabled clock, and flags terminal count. It runs either one-shot or auto-reload, and serves as the timeout/period generator beside the up-counters in the sequential-logic library.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..32)

Ports:
clk  input  1  clock; all state changes on its rising edge
reset  input  1  reset, synchronous, active-high
start  input  1  load load_val and begin counting; sampled every cycle
stop  input  1  abort counting and return to IDLE
en  input  1  count enable; 0 pauses decrement while running
auto_reload  input  1  mode select, sampled only on an accepted start; 1 = periodic, 0 = one-shot
load_val  input  WIDTH  start/reload value, sampled only on an accepted start
q  output  WIDTH  current count (registered)
busy  output  1  high while in RUN
tc  output  1  terminal-count pulse; high for exactly one cycle
done  output  1  high in DONE (one-shot expired); held until next start or reset

Behaviour:
- Reset (synchronous, highest priority, any state, including mid-count) sets:
  - q = 0, reload register = 0, mode register = 0, state = IDLE
  - busy = 0, tc = 0, done = 0
- States: IDLE, RUN, DONE. busy = (state == RUN). done = (state == DONE). All outputs are registered; there are no combinational input-to-output paths.
- Priority after reset: stop > start > en.
- Accepted start: start = 1, stop = 0, load_val != 0, in any state.
  - Next edge: q <= load_val, reload register <= load_val, mode register <= auto_reload, state <= RUN, tc <= 0.
  - A start in RUN restarts immediately; the old count is discarded and no tc is produced.
  - A start in DONE clears done.
- start with load_val == 0 is ignored: state, q, and the registers are unchanged, and tc stays 0.
- RUN, en = 1, q > 1: q <= q - 1.
- RUN, en = 1, q == 1 (terminal):
  - One-shot: q <= 0, tc <= 1, state <= DONE.
  - Auto-reload: q <= reload register, tc <= 1, state stays RUN.
  - tc rises on the same edge q takes its terminal/reload value.
  - Auto-reload period = load_val enabled cycles exactly; q never shows 0 in auto-reload.
- RUN, en = 0: q holds, busy stays 1, tc = 0.
- tc is 0 in every cycle not covered by the terminal rule above.
- stop = 1 in RUN: state <= IDLE on the next edge, q holds its current value, tc = 0, done = 0.
- stop in IDLE or DONE has no effect.
- IDLE and DONE: q holds, en is ignored.
- Latency:
  - start to first decrement: the first enabled edge after the load edge.
  - One-shot with load_val = N and en held high: tc and done assert N cycles after the load edge.
- Width: q never wraps below 0 and never exceeds load_val. load_val = 2^WIDTH-1 is legal (15 for WIDTH=4); the decrement must count all the way down with no overflow.

Test Plan:
1. Reset held 2 cycles during RUN with q=9 -> next edge q=0, busy=0, tc=0, done=0; stays IDLE with en=1.
2. One-shot: start with load_val=5, auto_reload=0, en=1 -> q sequence 5,4,3,2,1,0; tc high only on the cycle q becomes 0; done=1 and busy=0 from then; q holds 0 for 10 further cycles.
3. Auto-reload: load_val=3, auto_reload=1, en=1 for 12 cycles -> q sequence 3,2,1,3,2,1,...; tc pulses every 3rd cycle (4 pulses); done never asserts.
4. Pause and stop: load_val=6, en low for 3 cycles at q=4 -> q holds 4, busy=1. Then stop -> IDLE, q=4, no tc. Then start with load_val=0 -> ignored, q stays 4.
5. Restart and priority: in RUN at q=7, start with load_val=2 -> q=2 next edge, no tc. Later, start and stop in the same cycle -> IDLE.
6. Max value: WIDTH=4, load_val=15, one-shot -> 15 distinct decrements to 0, one tc, no wrap to 15.

Source files
------------

// File: rtl/down_counter_sync_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Flags terminal count with a single-cycle tc pulse; done holds after a one-shot expires.
module down_counter_sync_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] reload_r, reload_nxt;
   logic             mode_r, mode_nxt;
   logic             tc_nxt;
   logic             start_ok;

   // A zero load value would never reach terminal count, so it is not a valid start.
   assign start_ok = start && !stop && (load_val != '0);

   // NOTE: every signal gets its default first, so no path through this block can infer a latch.
   always_comb begin
      state_nxt  = state;
      q_nxt      = q;
      reload_nxt = reload_r;
      mode_nxt   = mode_r;
      tc_nxt     = 1'b0;
      if (stop && state == RUN) begin
         state_nxt = IDLE;
      end else if (start_ok) begin
         q_nxt      = load_val;
         reload_nxt = load_val;
         mode_nxt   = auto_reload;
         state_nxt  = RUN;
      end else if (state == RUN && en) begin
         if (q == ONE) begin
            tc_nxt = 1'b1;
            if (mode_r) begin
               q_nxt = reload_r;
            end else begin
               q_nxt     = '0;
               state_nxt = DONE;
            end
         end else if (q > ONE) begin
            q_nxt = q - ONE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         q        <= '0;
         reload_r <= '0;
         mode_r   <= 1'b0;
         tc       <= 1'b0;
      end else begin
         state    <= state_nxt;
         q        <= q_nxt;
         reload_r <= reload_nxt;
         mode_r   <= mode_nxt;
         tc       <= tc_nxt;
      end
   end

   // Decoded straight from the state register, so these remain registered outputs.
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter_sync_timer.sv
// Self-checking bench for down_counter_sync_timer: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_down_counter_sync_timer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, start, stop, en, auto_reload;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic         busy, tc, done;

   int total = 0;
   int bad   = 0;

   // Reference model: count value, reload value, mode, phase (0 idle, 1 run, 2 done), tc.
   int m_q, m_rel, m_mode, m_phase, m_tc;

   down_counter_sync_timer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
      .auto_reload(auto_reload), .load_val(load_val),
      .q(q), .busy(busy), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   function automatic void model_step(input int r, s, p, e, a, lv);
      if (r != 0) begin
         m_q = 0; m_rel = 0; m_mode = 0; m_phase = 0; m_tc = 0;
         return;
      end
      m_tc = 0;
      if (p != 0 && m_phase == 1) begin
         m_phase = 0;
      end else if (s != 0 && p == 0 && lv != 0) begin
         m_q = lv; m_rel = lv; m_mode = a; m_phase = 1;
      end else if (m_phase == 1 && e != 0) begin
         m_q = m_q - 1;
         if (m_q == 0) begin
            m_tc = 1;
            if (m_mode != 0) m_q = m_rel;
            else m_phase = 2;
         end
      end
   endfunction

   // Drive one cycle of inputs, clock it, advance the model, then settle past the edge.
   task automatic cyc(input logic r, s, p, e, a, input logic [W-1:0] lv);
      @(negedge clk);
      reset = r; start = s; stop = p; en = e; auto_reload = a; load_val = lv;
      @(posedge clk);
      model_step(int'(r), int'(s), int'(p), int'(e), int'(a), int'(lv));
      #1;
   endtask

   task automatic test_reset();
      logic [W+2:0] exp;
      cyc(0, 1, 0, 1, 0, 4'd10);
      cyc(0, 0, 0, 1, 0, 4'd0);
      total++;
      if ({q, busy, tc, done} !== {4'd9, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL reset_setup got q=%0d busy=%0b want q=9 busy=1", q, busy);
         bad++;
      end
      exp = {4'd0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         cyc(1, 0, 0, 1, 0, 4'd0);
         total++;
         if ({q, busy, tc, done} !== exp) begin
            $display("FAIL reset_hold[%0d] got %b want %b", i, {q, busy, tc, done}, exp);
            bad++;
         end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1, 0, 4'd0);
         total++;
         if ({q, busy, tc, done} !== exp) begin
            $display("FAIL reset_idle_en[%0d] got %b want %b", i, {q, busy, tc, done}, exp);
            bad++;
         end
      end
   endtask

   task automatic test_oneshot();
      logic [W+2:0] exp;
      cyc(0, 1, 0, 1, 0, 4'd5);
      total++;
      if ({q, busy, tc, done} !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL oneshot_load got %b want %b", {q, busy, tc, done}, {4'd5, 3'b100});
         bad++;
      end
      for (int k = 1; k <= 5; k++) begin
         cyc(0, 0, 0, 1, 0, 4'd0);
         exp = (k == 5) ? {4'd0, 1'b0, 1'b1, 1'b1} : {W'(5 - k), 1'b1, 1'b0, 1'b0};
         total++;
         if ({q, busy, tc, done} !== exp) begin
            $display("FAIL oneshot_step[%0d] got %b want %b", k, {q, busy, tc, done}, exp);
            bad++;
         end
      end
      for (int k = 0; k < 10; k++) begin
         cyc(0, 0, 0, 1, 0, 4'd0);
         total++;
         if ({q, busy, tc, done} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL oneshot_hold[%0d] got %b want %b", k, {q, busy, tc, done}, {4'd0, 3'b001});
            bad++;
         end
      end
   endtask

   task automatic test_autoreload();
      int pulses = 0;
      logic [W+2:0] exp;
      cyc(0, 1, 0, 1, 1, 4'd3);
      for (int k = 1; k <= 12; k++) begin
         cyc(0, 0, 0, 1, 0, 4'd0);
         if (tc) pulses++;
         exp = {W'(3 - (k % 3)), 1'b1, (k % 3) == 0, 1'b0};
         total++;
         if ({q, busy, tc, done} !== exp) begin
            $display("FAIL autoreload_step[%0d] got %b want %b", k, {q, busy, tc, done}, exp);
            bad++;
         end
      end
      total++;
      if (pulses != 4) begin
         $display("FAIL autoreload_pulses got %0d want 4", pulses);
         bad++;
      end
   endtask

   task automatic test_pause_stop();
      cyc(0, 1, 0, 1, 0, 4'd6);
      cyc(0, 0, 0, 1, 0, 4'd0);
      cyc(0, 0, 0, 1, 0, 4'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 0, 4'd0);
         total++;
         if ({q, busy, tc, done} !== {4'd4, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL pause[%0d] got %b want %b", k, {q, busy, tc, done}, {4'd4, 3'b100});
            bad++;
         end
      end
      cyc(0, 0, 1, 1, 0, 4'd0);
      total++;
      if ({q, busy, tc, done} !== {4'd4, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL stop got %b want %b", {q, busy, tc, done}, {4'd4, 3'b000});
         bad++;
      end
      cyc(0, 1, 0, 1, 1, 4'd0);
      cyc(0, 0, 0, 1, 0, 4'd0);
      total++;
      if ({q, busy, tc, done} !== {4'd4, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL zero_load_ignored got %b want %b", {q, busy, tc, done}, {4'd4, 3'b000});
         bad++;
      end
   endtask

   task automatic test_restart();
      cyc(0, 1, 0, 1, 0, 4'd9);
      cyc(0, 0, 0, 1, 0, 4'd0);
      cyc(0, 0, 0, 1, 0, 4'd0);
      total++;
      if (q !== 4'd7) begin
         $display("FAIL restart_setup got q=%0d want q=7", q);
         bad++;
      end
      cyc(0, 1, 0, 1, 0, 4'd2);
      total++;
      if ({q, busy, tc, done} !== {4'd2, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL restart_load got %b want %b", {q, busy, tc, done}, {4'd2, 3'b100});
         bad++;
      end
      cyc(0, 0, 0, 1, 0, 4'd0);
      // q is now 1: stop must beat both the start and the terminal decrement.
      cyc(0, 1, 1, 1, 0, 4'd5);
      total++;
      if ({q, busy, tc, done} !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL start_stop_priority got %b want %b", {q, busy, tc, done}, {4'd1, 3'b000});
         bad++;
      end
   endtask

   task automatic test_max();
      int pulses = 0;
      cyc(0, 1, 0, 1, 0, 4'd15);
      total++;
      if (q !== 4'd15) begin
         $display("FAIL max_load got q=%0d want q=15", q);
         bad++;
      end
      for (int k = 1; k <= 18; k++) begin
         cyc(0, 0, 0, 1, 0, 4'd0);
         if (tc) pulses++;
         total++;
         if (q !== W'((k < 15) ? 15 - k : 0)) begin
            $display("FAIL max_step[%0d] got q=%0d want q=%0d", k, q, (k < 15) ? 15 - k : 0);
            bad++;
         end
      end
      total++;
      if (pulses != 1 || done !== 1'b1) begin
         $display("FAIL max_tc got pulses=%0d done=%0b want pulses=1 done=1", pulses, done);
         bad++;
      end
      cyc(0, 1, 0, 1, 0, 4'd2);
      total++;
      if ({q, busy, tc, done} !== {4'd2, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL start_from_done got %b want %b", {q, busy, tc, done}, {4'd2, 3'b100});
         bad++;
      end
   endtask

   task automatic test_random();
      logic [W+2:0] exp;
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 97) == 0, ($urandom % 9) == 0, ($urandom % 13) == 0,
             ($urandom % 4) != 0, $urandom % 2, W'($urandom_range(0, 15)));
         exp = {W'(m_q), m_phase == 1, m_tc != 0, m_phase == 2};
         total++;
         if ({q, busy, tc, done} !== exp) begin
            $display("FAIL random[%0d] got %b want %b", i, {q, busy, tc, done}, exp);
            bad++;
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = '0;
      m_q = 0; m_rel = 0; m_mode = 0; m_phase = 0; m_tc = 0;
      cyc(1, 0, 0, 0, 0, 4'd0);
      cyc(1, 0, 0, 0, 0, 4'd0);
      cyc(0, 0, 0, 0, 0, 4'd0);
      test_reset();
      test_oneshot();
      test_autoreload();
      test_pause_stop();
      test_restart();
      test_max();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
